alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ALU operand/result width.
REQ-002 SHALL have parameter NREGS, default 4, register-file depth.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instr_valid  input  1  instruction word offered.
REQ-006 instr  input  16  instruction: [15:12] op, [11:10] rd, [9:8] rs, [7] mode, [6:0] imm7 (mode=1) or [1:0] rt (mode=0).
REQ-007 instr_ready  output  1  block accepts instr this cycle.
REQ-008 alu_A  output  DATA_W  operand A to downstream ALU.
REQ-009 alu_B  output  DATA_W  operand B to downstream ALU.
REQ-010 alu_op  output  4  opcode to downstream ALU.
REQ-011 alu_E  input  DATA_W  ALU result, combinational from alu_A/alu_B/alu_op.
REQ-012 alu_cc  input  2  ALU condition code, combinational.
REQ-013 cc_q  output  2  last captured condition code.
REQ-014 wb_valid  output  1  one-cycle pulse: register write occurred.
REQ-015 wb_addr  output  2  register written; wb_data  output  DATA_W  value written.
REQ-016 dbg_addr  input  2 / dbg_data  output  DATA_W  combinational register read port.

Function
REQ-017 SHALL implement FSM states IDLE and EXEC.
REQ-018 IDLE: instr_ready=1; instr_valid=1 at edge N accepts instr, moves to EXEC.
REQ-019 On accept, SHALL register alu_op=instr[15:12], alu_A=R[rs], alu_B=R[rt] (mode=0) or zero-extended imm7 (mode=1); valid from edge N until next accept.
REQ-020 EXEC lasts exactly one cycle; instr_ready=0; instr/instr_valid ignored.
REQ-021 At edge N+1 SHALL write alu_E into R[rd], alu_cc into cc_q, return to IDLE.
REQ-022 wb_valid=1, wb_addr=rd, wb_data=written value for the cycle after edge N+1; otherwise wb_valid=0, wb_addr/wb_data hold.
REQ-023 Throughput one instruction per 2 cycles; back-to-back valid accepted every other cycle.
REQ-024 Instruction accepted in IDLE after a write SHALL read the updated register (no stale data; rd==rs legal).
REQ-025 All four registers writable; no hardwired zero register.
REQ-026 Result width truncated to DATA_W; no sign extension of imm7.

Reset
REQ-027 rst at any edge SHALL force state IDLE, R[0..3]=0, cc_q=0, alu_A=alu_B=0, alu_op=0, wb_valid=0, wb_addr=0, wb_data=0.
REQ-028 rst during EXEC SHALL abort: no register/cc_q write, no wb_valid pulse.
REQ-029 rst overrides simultaneous instr_valid; instr_ready=1 in first cycle after reset released.

Structure
REQ-030 Shared package tinycpu_pkg SHALL hold instruction field positions, opcode width, DATA_W default, FSM state encoding.
REQ-031 Register file SHALL be sub-module regfile_4x8: one synchronous write port, two combinational read ports plus debug read port.

Verification (bench drives alu_E/alu_cc from a stub)
REQ-032 Reset, release -> dbg_data=0 for all addresses, cc_q=0, instr_ready=1, wb_valid=0.
REQ-033 instr op=0,rd=1,rs=0,mode=1,imm=2 at edge N -> alu_A=0,alu_B=2,alu_op=0 after N; stub E=03,cc=01 -> R1=03, cc_q=01, wb_valid pulse wb_addr=1 wb_data=03.
REQ-034 Following instr op=0,rd=2,rs=1,mode=0,rt=1 -> alu_A=03, alu_B=03; stub E=06 -> R2=06.
REQ-035 instr_valid held high 6 cycles with distinct instrs -> exactly 3 accepted, instr_ready toggles 1,0,1,0,1,0.
REQ-036 rst asserted in EXEC of instr rd=3 -> R3 stays 0, cc_q=0, no wb_valid.
REQ-037 rd=rs=1 increment (stub E=A+1) issued twice from R1=03 -> R1=05, proving read-after-write.

Source files
------------

// File: rtl/tinycpu_pkg.sv
// Shared definitions for the tiny issue stage: instruction layout,
// widths and FSM state encoding.
package tinycpu_pkg;

  localparam int OP_W       = 4;
  localparam int REG_AW     = 2;
  localparam int IMM_W      = 7;
  localparam int DATA_W_DEF = 8;
  localparam int INSTR_W    = 16;

  // Field order matches bit positions: op[15:12] rd[11:10] rs[9:8] mode[7] imm7[6:0]
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic              mode;
    logic [IMM_W-1:0]  imm7;
  } instr_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  function automatic logic [REG_AW-1:0] get_rt(input instr_t i);
    return i.imm7[REG_AW-1:0];
  endfunction

endpackage

// File: rtl/regfile_4x8.sv
// Register file: one synchronous write port, two combinational operand
// read ports and a combinational debug read port.
module regfile_4x8
  import tinycpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [REG_AW-1:0] i_raddr_dbg,
  output logic [DATA_W-1:0] o_rdata_dbg
);

  logic [DATA_W-1:0] r_mem [NREGS];

  // NOTE: the array is small flops, not a RAM macro, so clearing it on reset is
  // legal and required; sequential state uses <= so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a   = r_mem[i_raddr_a];
  assign o_rdata_b   = r_mem[i_raddr_b];
  assign o_rdata_dbg = r_mem[i_raddr_dbg];

endmodule

// File: rtl/alu_issue.sv
// Two-state issue stage: latches operands for an external combinational ALU,
// then writes its result back into the register file one cycle later.
module alu_issue
  import tinycpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  alu_A,
  output logic [DATA_W-1:0]  alu_B,
  output logic [OP_W-1:0]    alu_op,
  input  logic [DATA_W-1:0]  alu_E,
  input  logic [1:0]         alu_cc,
  output logic [1:0]         cc_q,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_e             r_state;
  state_e             w_next_state;
  logic               w_accept;
  logic               w_we;
  instr_t             w_instr;
  logic [DATA_W-1:0]  w_rs_data;
  logic [DATA_W-1:0]  w_rt_data;
  logic [DATA_W-1:0]  w_imm;

  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [OP_W-1:0]    r_alu_op;
  logic [REG_AW-1:0]  r_rd;
  logic [1:0]         r_cc;
  logic               r_wb_valid;
  logic [REG_AW-1:0]  r_wb_addr;
  logic [DATA_W-1:0]  r_wb_data;

  assign w_instr = instr_t'(instr);
  assign w_imm   = DATA_W'(w_instr.imm7);

  regfile_4x8 #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .i_we        (w_we),
    .i_waddr     (r_rd),
    .i_wdata     (alu_E),
    .i_raddr_a   (w_instr.rs),
    .o_rdata_a   (w_rs_data),
    .i_raddr_b   (get_rt(w_instr)),
    .o_rdata_b   (w_rt_data),
    .i_raddr_dbg (dbg_addr),
    .o_rdata_dbg (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    instr_ready  = 1'b0;
    w_accept     = 1'b0;
    w_we         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        w_we         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Reset has priority over the EXEC write, which is what aborts an in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_rd       <= '0;
      r_cc       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_accept) begin
        r_alu_op <= w_instr.op;
        r_alu_a  <= w_rs_data;
        r_alu_b  <= w_instr.mode ? w_imm : w_rt_data;
        r_rd     <= w_instr.rd;
      end
      if (w_we) begin
        r_cc       <= alu_cc;
        r_wb_valid <= 1'b1;
        r_wb_addr  <= r_rd;
        r_wb_data  <= alu_E;
      end
    end
  end

  assign alu_A    = r_alu_a;
  assign alu_B    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign cc_q     = r_cc;
  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_wb_addr;
  assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a stub ALU, a write-back scoreboard fed at
// issue time and a monitor that drains it on every wb_valid pulse.
module tb_alu_issue;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  alu_A, alu_B, alu_E;
  logic [3:0]  alu_op;
  logic [1:0]  alu_cc, cc_q;
  logic        wb_valid;
  logic [1:0]  wb_addr, dbg_addr;
  logic [7:0]  wb_data, dbg_data;

  logic        stub_force = 1'b0;
  logic [7:0]  stub_e     = '0;
  logic [1:0]  stub_cc    = '0;

  wb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  alu_issue #(.DATA_W(8), .NREGS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_op      (alu_op),
    .alu_E       (alu_E),
    .alu_cc      (alu_cc),
    .cc_q        (cc_q),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Stub ALU: op0 add, op1 increment A, otherwise xor; cc = {negative, zero}.
  always_comb begin
    alu_E  = '0;
    alu_cc = '0;
    if (stub_force) begin
      alu_E  = stub_e;
      alu_cc = stub_cc;
    end else begin
      case (alu_op)
        4'h0:    alu_E = alu_A + alu_B;
        4'h1:    alu_E = alu_A + 8'd1;
        default: alu_E = alu_A ^ alu_B;
      endcase
      alu_cc = {alu_E[7], alu_E == 8'd0};
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic check_reg(input logic [1:0] a, input logic [7:0] exp, input string name);
    dbg_addr = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  // Offers one instruction at a negedge and returns 1 time unit after the accept edge.
  task automatic issue(input logic [15:0] w, input logic [1:0] a, input logic [7:0] d,
                       input bit expect_wb);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready_timeout", instr_ready, 1'b1);
    if (expect_wb) sb_q.push_back('{addr: a, data: d});
    instr_valid = 1'b1;
    instr       = w;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected_pulse", wb_valid, 1'b0);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        check("wb_addr", wb_addr, e.addr);
        check("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] vec [6];
    logic        rdy_exp [6];
    int          n;

    vec[0] = 16'h0091; vec[1] = 16'h0CFF; vec[2] = 16'h0C85;
    vec[3] = 16'h04C0; vec[4] = 16'h0381; vec[5] = 16'h08B3;
    rdy_exp[0] = 1'b1; rdy_exp[1] = 1'b0; rdy_exp[2] = 1'b1;
    rdy_exp[3] = 1'b0; rdy_exp[4] = 1'b1; rdy_exp[5] = 1'b0;

    // Reset with a valid instruction offered: reset must win.
    rst         = 1'b1;
    instr_valid = 1'b1;
    instr       = 16'h0CAA;
    dbg_addr    = '0;
    repeat (3) @(negedge clk);
    rst         = 1'b0;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_instr_ready", instr_ready, 1'b1);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_cc_q", cc_q, 2'b00);
    check("rst_alu_A", alu_A, 8'h00);
    check("rst_alu_B", alu_B, 8'h00);
    check("rst_alu_op", alu_op, 4'h0);
    for (int i = 0; i < 4; i++) check_reg(2'(i), 8'h00, $sformatf("rst_R%0d", i));

    // op0 rd1 rs0 imm=2, stub forces E=03 cc=01.
    stub_force = 1'b1;
    stub_e     = 8'h03;
    stub_cc    = 2'b01;
    issue(16'h0482, 2'd1, 8'h03, 1'b1);
    check("t1_alu_A", alu_A, 8'h00);
    check("t1_alu_B", alu_B, 8'h02);
    check("t1_alu_op", alu_op, 4'h0);
    check("t1_ready_in_exec", instr_ready, 1'b0);
    @(posedge clk);
    #1;
    stub_force = 1'b0;
    check("t1_cc_q", cc_q, 2'b01);
    check("t1_alu_A_hold", alu_A, 8'h00);
    check("t1_alu_B_hold", alu_B, 8'h02);
    check_reg(2'd1, 8'h03, "t1_R1");

    // op0 rd2 rs1 rt1 register mode: 03 + 03 = 06.
    issue(16'h0901, 2'd2, 8'h06, 1'b1);
    check("t2_alu_A", alu_A, 8'h03);
    check("t2_alu_B", alu_B, 8'h03);
    @(posedge clk);
    #1;
    check_reg(2'd2, 8'h06, "t2_R2");
    check("t2_cc_q", cc_q, 2'b00);

    // instr_valid held for six cycles: only vec[0], vec[2], vec[4] are taken.
    sb_q.push_back('{addr: 2'd0, data: 8'h11});
    sb_q.push_back('{addr: 2'd3, data: 8'h16});
    sb_q.push_back('{addr: 2'd0, data: 8'h17});
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      instr       = vec[k];
      instr_valid = 1'b1;
      check($sformatf("b2b_ready_%0d", k), instr_ready, rdy_exp[k]);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check_reg(2'd0, 8'h17, "b2b_R0");
    check_reg(2'd1, 8'h03, "b2b_R1");
    check_reg(2'd2, 8'h06, "b2b_R2");
    check_reg(2'd3, 8'h16, "b2b_R3");

    // Reset during EXEC of an rd=3 instruction: no write, no pulse.
    issue(16'h0CAA, 2'd3, 8'h2A, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_wb_valid", wb_valid, 1'b0);
    check("abort_cc_q", cc_q, 2'b00);
    check("abort_ready", instr_ready, 1'b1);
    check_reg(2'd3, 8'h00, "abort_R3");
    check_reg(2'd0, 8'h00, "abort_R0");

    // Read-after-write: R1=03, then R1=R1+1 twice.
    issue(16'h0483, 2'd1, 8'h03, 1'b1);
    issue(16'h1580, 2'd1, 8'h04, 1'b1);
    check("raw_alu_A_1", alu_A, 8'h03);
    issue(16'h1580, 2'd1, 8'h05, 1'b1);
    check("raw_alu_A_2", alu_A, 8'h04);
    @(posedge clk);
    #1;
    check_reg(2'd1, 8'h05, "raw_R1");

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", sb_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
